// File: rtl/gobou_ctrl_seq.sv
// gobou_ctrl_seq
// Successor sequencer for the gobou fully-connected engine. For each of
// total_batch input vectors it walks the output neurons CORE at a time:
// one input element plus one weight word per unstalled cycle, an optional
// bias cycle, then it collects the serialised results into image memory.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req / ack           start pulse (taken only in S_WAIT with all totals
//                       nonzero) / idle-done flag
//   img_we, write_img   host image writes, honoured only in S_WAIT
//   input_addr, output_addr, net_addr, total_in, total_out, total_batch,
//   bias_en             job description, latched on an accepted req
//   net_we              host weight write select (k = core k-1, 0 = none)
//   write_result        serialised result data from the datapath
//   stall               datapath back-pressure for S_WEIGHT / S_BIAS
//   res_start           serialiser start, honoured only in S_OUTPUT
//   out_start/out_valid/out_stop   group framing to the MAC cores
//   mem_img_*, write_mem_img       image memory port
//   mem_net_we, mem_net_addr       network memory port
//   breg_we, serial_we             bias register / serialiser loads
//
// Flow control: req/ack is a level handshake (ack low while busy). stall is
// the only back-pressure: while high, a S_WEIGHT/S_BIAS cycle does not
// count and produces no out_valid. There is no ready on the result side;
// once res_start is seen, n_valid results are written on consecutive cycles.
module gobou_ctrl_seq #(
  parameter int CORE    = 8,
  parameter int CORELOG = 3,
  parameter int DWIDTH  = 16,
  parameter int LWIDTH  = 12,
  parameter int IMGSIZE = 16,
  parameter int NETSIZE = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  output logic               ack,
  input  logic               img_we,
  input  logic [IMGSIZE-1:0] input_addr,
  input  logic [IMGSIZE-1:0] output_addr,
  input  logic [NETSIZE-1:0] net_addr,
  input  logic [DWIDTH-1:0]  write_img,
  input  logic [DWIDTH-1:0]  write_result,
  input  logic [CORELOG:0]   net_we,
  input  logic [LWIDTH-1:0]  total_in,
  input  logic [LWIDTH-1:0]  total_out,
  input  logic [LWIDTH-1:0]  total_batch,
  input  logic               bias_en,
  input  logic               stall,
  input  logic               res_start,
  output logic               out_start,
  output logic               out_valid,
  output logic               out_stop,
  output logic               mem_img_we,
  output logic [IMGSIZE-1:0] mem_img_addr,
  output logic [DWIDTH-1:0]  write_mem_img,
  output logic [CORE-1:0]    mem_net_we,
  output logic [NETSIZE-1:0] mem_net_addr,
  output logic               breg_we,
  output logic               serial_we
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_WEIGHT = 2'd1,
    S_BIAS   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched job description
  logic [IMGSIZE-1:0] input_base, output_base;
  logic [NETSIZE-1:0] net_base;
  logic [LWIDTH-1:0]  tot_in, tot_out, tot_batch;
  logic               bias_r;

  // Progress counters
  logic [LWIDTH-1:0]  batch_cnt, count_out, count_in, wr_cnt;
  logic [IMGSIZE-1:0] in_base, out_cnt;
  logic [NETSIZE-1:0] net_cnt;
  logic               writing;
  logic               stop_pre;

  logic               accept;
  logic               last_in;
  logic               last_wr;
  logic               more_groups;
  logic               more_batch;
  logic               group_done;
  logic [LWIDTH-1:0]  remaining;
  logic [LWIDTH-1:0]  n_valid;
  logic [CORE-1:0]    net_sel;

  assign accept      = (state == S_WAIT) && req && (total_in != '0) &&
                       (total_out != '0) && (total_batch != '0);
  assign last_in     = (count_in == tot_in - LWIDTH'(1));
  assign remaining   = tot_out - count_out;
  assign n_valid     = (remaining >= LWIDTH'(CORE)) ? LWIDTH'(CORE) : remaining;
  assign last_wr     = (state == S_OUTPUT) && writing && (wr_cnt == n_valid - LWIDTH'(1));
  assign more_groups = (LWIDTH'(count_out + LWIDTH'(CORE)) < tot_out);
  assign more_batch  = (batch_cnt < tot_batch - LWIDTH'(1));
  // Final write of a group that is followed by more work
  assign group_done  = last_wr && (more_groups || more_batch);

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (accept) state_nxt = S_WEIGHT;
      S_WEIGHT: if (!stall && last_in) state_nxt = bias_r ? S_BIAS : S_OUTPUT;
      S_BIAS:   if (!stall) state_nxt = S_OUTPUT;
      S_OUTPUT: if (last_wr) state_nxt = (more_groups || more_batch) ? S_WEIGHT : S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    net_sel = '0;
    for (int i = 0; i < CORE; i++) begin
      net_sel[i] = (net_we == (CORELOG+1)'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_WAIT;
      input_base  <= '0;
      output_base <= '0;
      net_base    <= '0;
      tot_in      <= '0;
      tot_out     <= '0;
      tot_batch   <= '0;
      bias_r      <= 1'b0;
      batch_cnt   <= '0;
      count_out   <= '0;
      count_in    <= '0;
      wr_cnt      <= '0;
      in_base     <= '0;
      out_cnt     <= '0;
      net_cnt     <= '0;
      writing     <= 1'b0;
      stop_pre    <= 1'b0;
      ack         <= 1'b1;
      out_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_stop    <= 1'b0;
      breg_we     <= 1'b0;
      serial_we   <= 1'b0;
      mem_net_we  <= '0;
    end else begin
      state      <= state_nxt;
      mem_net_we <= net_sel;
      out_start  <= accept || group_done;
      out_valid  <= ((state == S_WEIGHT) || (state == S_BIAS)) && !stall;
      breg_we    <= (state == S_BIAS) && !stall;
      // Last counted cycle of a group; out_stop follows the last out_valid.
      stop_pre   <= !stall && (((state == S_WEIGHT) && last_in && !bias_r) ||
                               (state == S_BIAS));
      out_stop   <= stop_pre;
      serial_we  <= (state == S_OUTPUT) && res_start;

      case (state)
        S_WAIT: begin
          if (accept) begin
            input_base  <= input_addr;
            output_base <= output_addr;
            net_base    <= net_addr;
            tot_in      <= total_in;
            tot_out     <= total_out;
            tot_batch   <= total_batch;
            bias_r      <= bias_en;
            batch_cnt   <= '0;
            count_out   <= '0;
            count_in    <= '0;
            wr_cnt      <= '0;
            in_base     <= '0;
            out_cnt     <= '0;
            net_cnt     <= '0;
            writing     <= 1'b0;
            ack         <= 1'b0;
          end
        end
        S_WEIGHT: begin
          if (!stall) begin
            net_cnt  <= net_cnt + NETSIZE'(1);
            count_in <= last_in ? '0 : count_in + LWIDTH'(1);
          end
        end
        S_BIAS: begin
          if (!stall) net_cnt <= net_cnt + NETSIZE'(1);
        end
        S_OUTPUT: begin
          if (!writing) begin
            if (res_start) begin
              writing <= 1'b1;
              wr_cnt  <= '0;
            end
          end else begin
            out_cnt <= out_cnt + IMGSIZE'(1);
            wr_cnt  <= wr_cnt + LWIDTH'(1);
            if (last_wr) begin
              writing <= 1'b0;
              if (more_groups) begin
                count_out <= count_out + LWIDTH'(CORE);
              end else if (more_batch) begin
                batch_cnt <= batch_cnt + LWIDTH'(1);
                count_out <= '0;
                in_base   <= in_base + IMGSIZE'(tot_in);
                net_cnt   <= '0;
              end else begin
                ack <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Image memory port: host loads in S_WAIT, result writes in S_OUTPUT,
  // input element reads in S_WEIGHT / S_BIAS.
  always_comb begin
    mem_img_we    = 1'b0;
    mem_img_addr  = input_base + in_base + IMGSIZE'(count_in);
    write_mem_img = write_img;
    case (state)
      S_WAIT: begin
        mem_img_we   = img_we;
        mem_img_addr = input_addr;
      end
      S_OUTPUT: begin
        mem_img_we    = writing;
        mem_img_addr  = output_base + out_cnt;
        write_mem_img = write_result;
      end
      default: ;
    endcase
  end

  assign mem_net_addr = net_base + net_cnt;

endmodule

// File: tb/tb_gobou_ctrl_seq.sv
// Directed bench for gobou_ctrl_seq (CORE=8 defaults).
module tb_gobou_ctrl_seq;
  localparam int CORE = 8, CORELOG = 3, DWIDTH = 16, LWIDTH = 12;
  localparam int IMGSIZE = 16, NETSIZE = 14;
  localparam int IB = 100, OB = 500, NB = 200;

  logic clk = 1'b0;
  logic rst;
  logic req, ack, img_we, bias_en, stall, res_start;
  logic [IMGSIZE-1:0] input_addr, output_addr, mem_img_addr;
  logic [NETSIZE-1:0] net_addr, mem_net_addr;
  logic [DWIDTH-1:0]  write_img, write_result, write_mem_img;
  logic [CORELOG:0]   net_we;
  logic [LWIDTH-1:0]  total_in, total_out, total_batch;
  logic out_start, out_valid, out_stop, mem_img_we, breg_we, serial_we;
  logic [CORE-1:0]    mem_net_we;

  gobou_ctrl_seq #(.CORE(CORE), .CORELOG(CORELOG), .DWIDTH(DWIDTH), .LWIDTH(LWIDTH),
                   .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .img_we(img_we),
    .input_addr(input_addr), .output_addr(output_addr), .net_addr(net_addr),
    .write_img(write_img), .write_result(write_result), .net_we(net_we),
    .total_in(total_in), .total_out(total_out), .total_batch(total_batch),
    .bias_en(bias_en), .stall(stall), .res_start(res_start),
    .out_start(out_start), .out_valid(out_valid), .out_stop(out_stop),
    .mem_img_we(mem_img_we), .mem_img_addr(mem_img_addr), .write_mem_img(write_mem_img),
    .mem_net_we(mem_net_we), .mem_net_addr(mem_net_addr),
    .breg_we(breg_we), .serial_we(serial_we)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Monitor: records per-cycle observations on the falling edge
  logic [31:0] obs_net[$], obs_img[$], obs_wa[$], obs_wd[$];
  logic [31:0] exp_net[$], exp_img[$], exp_wa[$];
  int cyc, n_val, n_start, n_stop, n_breg, n_ser, ser_bad, stop_bad;
  int gap, grp_val, start_cyc, last_we, ack_cyc;
  logic prev_valid, prev_ack;
  logic [31:0] prev_net, prev_img;
  logic mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      obs_net.delete(); obs_img.delete(); obs_wa.delete(); obs_wd.delete();
      cyc = 0; n_val = 0; n_start = 0; n_stop = 0; n_breg = 0; n_ser = 0;
      ser_bad = 0; stop_bad = 0; gap = 0; grp_val = 0; start_cyc = 0;
      last_we = 0; ack_cyc = -1; prev_valid = 1'b0; prev_ack = 1'b1;
      prev_net = '0; prev_img = '0;
    end else if (!rst) begin
      cyc++;
      if (out_valid) begin
        obs_net.push_back(prev_net);
        obs_img.push_back(prev_img);
        n_val++;
        grp_val++;
      end
      if (out_start) begin
        n_start++;
        start_cyc = cyc;
        grp_val = 0;
      end
      if (out_stop) begin
        n_stop++;
        gap += cyc - start_cyc - 1 - grp_val;
        if (out_valid || !prev_valid) stop_bad++;
      end
      if (breg_we) n_breg++;
      if (serial_we) begin
        n_ser++;
        if (!mem_img_we) ser_bad++;
      end
      if (mem_img_we) begin
        obs_wa.push_back(32'(mem_img_addr));
        obs_wd.push_back(32'(write_mem_img));
        last_we = cyc;
      end
      if (ack && !prev_ack) ack_cyc = cyc;
      prev_ack   = ack;
      prev_valid = out_valid;
      prev_net   = 32'(mem_net_addr);
      prev_img   = 32'(mem_img_addr);
    end
  end

  // Driver tasks
  task automatic wait_stop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_stop) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_req(input int ti, input int to, input int tbt, input bit bias);
    input_addr  = IMGSIZE'(IB);
    output_addr = IMGSIZE'(OB);
    net_addr    = NETSIZE'(NB);
    total_in    = LWIDTH'(ti);
    total_out   = LWIDTH'(to);
    total_batch = LWIDTH'(tbt);
    bias_en     = bias;
    req         = 1'b1;
    @(negedge clk);
    req = 1'b0;
    // Scramble job inputs to show they were latched
    input_addr  = '1;
    output_addr = 16'hEEEE;
    net_addr    = '1;
    total_in    = 12'd1;
    total_out   = 12'd1;
    total_batch = 12'd7;
    bias_en     = ~bias;
  endtask

  task automatic cmp_q(input string tag, input logic [31:0] got_q[$], input logic [31:0] exp_q[$]);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
  endtask

  task automatic run_case(input int ti, input int to, input int tbt, input bit bias,
                          input bit do_stall, input int id);
    int gp, ng;
    bit ok;
    gp = (to + CORE - 1) / CORE;
    ng = gp * tbt;
    exp_net.delete(); exp_img.delete(); exp_wa.delete();
    for (int b = 0; b < tbt; b++)
      for (int g = 0; g < gp; g++) begin
        for (int k = 0; k < ti; k++) begin
          exp_net.push_back(32'(NB + g * (ti + bias) + k));
          exp_img.push_back(32'(IB + b * ti + k));
        end
        if (bias) begin
          exp_net.push_back(32'(NB + g * (ti + 1) + ti));
          exp_img.push_back(32'(IB + b * ti));
        end
      end
    for (int j = 0; j < tbt * to; j++) exp_wa.push_back(32'(OB + j));
    write_result = 16'h5A00 + DWIDTH'(id);

    mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clr = 1'b0;
    start_req(ti, to, tbt, bias);
    check("ack_fall", ack, 0);
    check("out_start_first", out_start, 1);
    if (do_stall) begin
      @(negedge clk);
      stall = 1'b1;
      repeat (3) @(negedge clk);
      stall = 1'b0;
    end
    for (int g = 0; g < ng; g++) begin
      wait_stop(ok);
      check("stop_seen", ok, 1);
      repeat (2) @(negedge clk);
      res_start = 1'b1;
      @(negedge clk);
      res_start = 1'b0;
    end
    for (int i = 0; i < 100 && !ack; i++) @(negedge clk);
    check("ack_done", ack, 1);
    @(negedge clk);

    cmp_q("net_addr", obs_net, exp_net);
    cmp_q("img_addr", obs_img, exp_img);
    cmp_q("wr_addr", obs_wa, exp_wa);
    for (int i = 0; i < obs_wd.size(); i++) check("wr_data", obs_wd[i], 32'h5A00 + 32'(id));
    check("n_valid", n_val, ng * (ti + bias));
    check("n_start", n_start, ng);
    check("n_stop", n_stop, ng);
    check("n_breg", n_breg, bias ? ng : 0);
    check("n_serial", n_ser, ng);
    check("serial_we_write", ser_bad, 0);
    check("stop_after_valid", stop_bad, 0);
    check("stall_gap", gap, do_stall ? 3 : 0);
    check("ack_latency", ack_cyc - last_we, 1);
  endtask

  initial begin
    bit ok;
    bit ack_dropped;
    int starts;
    rst = 1'b1; req = 1'b0; img_we = 1'b0; bias_en = 1'b0; stall = 1'b0;
    res_start = 1'b0; input_addr = '0; output_addr = '0; net_addr = '0;
    write_img = '0; write_result = '0; net_we = '0;
    total_in = '0; total_out = '0; total_batch = '0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_ack", ack, 1);
    check("rst_out_start", out_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_stop", out_stop, 0);
    check("rst_mem_img_we", mem_img_we, 0);
    check("rst_mem_img_addr", mem_img_addr, 0);
    check("rst_mem_net_we", mem_net_we, 0);
    check("rst_mem_net_addr", mem_net_addr, 0);
    check("rst_breg_we", breg_we, 0);
    check("rst_serial_we", serial_we, 0);
    rst = 1'b0;
    @(negedge clk);

    // Host weight select and image write path
    net_we = 4'd3;
    @(negedge clk);
    check("net_we_3", mem_net_we, 8'b0000_0100);
    net_we = 4'd8;
    img_we = 1'b1; write_img = 16'h1234; input_addr = 16'd42;
    @(negedge clk);
    check("net_we_8", mem_net_we, 8'b1000_0000);
    check("host_img_we", mem_img_we, 1);
    check("host_img_addr", mem_img_addr, 42);
    check("host_img_data", write_mem_img, 16'h1234);
    net_we = 4'd0; img_we = 1'b0;
    @(negedge clk);
    check("net_we_0", mem_net_we, 0);

    // Zero total_in request is ignored
    input_addr = 16'd0; total_in = 12'd0; total_out = 12'd8; total_batch = 12'd1;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    ack_dropped = 1'b0; starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (!ack) ack_dropped = 1'b1;
      if (out_start || out_valid) starts++;
      @(negedge clk);
    end
    check("zero_req_ack", ack_dropped, 0);
    check("zero_req_start", starts, 0);

    run_case(4, 8, 1, 1'b1, 1'b0, 1);   // single group with bias
    run_case(3, 10, 1, 1'b1, 1'b0, 2);  // partial second group
    run_case(5, 4, 3, 1'b1, 1'b0, 3);   // batched
    run_case(4, 16, 1, 1'b0, 1'b0, 4);  // no bias, two full groups
    run_case(6, 8, 1, 1'b0, 1'b1, 5);   // stall mid-weight

    // Reset during result writes
    start_req(2, 8, 1, 1'b0);
    wait_stop(ok);
    check("rst_case_stop", ok, 1);
    repeat (2) @(negedge clk);
    res_start = 1'b1;
    @(negedge clk);
    res_start = 1'b0;
    @(negedge clk);
    check("pre_rst_writing", mem_img_we, 1);
    check("pre_rst_ack", ack, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", ack, 1);
    check("async_rst_we", mem_img_we, 0);
    check("async_rst_serial", serial_we, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_we", mem_img_we, 0);

    run_case(4, 8, 1, 1'b1, 1'b0, 6);   // accepted normally after reset

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
